operand_fetch_stage: RTL

Pipeline stage directly upstream of the 32×32 register file. It drives the file's two read addresses and captures both read operands into an output register. It forwards same-cycle write-back data that the file has not yet stored, and keeps a 32-entry pending-write scoreboard. Upstream (decode) and downstream (execute) connect through valid/ready handshakes, and the stage stalls decode on RAW/WAW hazards.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/scoreboard.sv | 31 +++
 rtl/operand_fetch_stage.sv | 81 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and register-file datapath types.
// No logic; imported by the operand fetch stage and its scoreboard.
package cpu_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 1 << ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] word_t;
   typedef logic [NREG-1:0]   busy_vec_t;
endpackage

// File: rtl/scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register; updates take one cycle.
// No backpressure; a set and a clear on the same index resolve to set (younger writer still pending).
module scoreboard
   import cpu_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   input  logic      set_en,
   input  reg_addr_t set_idx,
   input  logic      clr_en,
   input  reg_addr_t clr_idx,
   output busy_vec_t busy
);

   busy_vec_t set_mask;
   busy_vec_t clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en) set_mask[set_idx] = 1'b1;
      if (clr_en) clr_mask[clr_idx] = 1'b1;
   end

   // Clear is applied first so a coincident set on the same index survives.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) busy <= '0;
      else        busy <= (busy & ~clr_mask) | set_mask;
   end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads the register file, bypasses same-cycle write-back, registers operands (1-cycle latency).
// Backpressure: in_ready drops while the output register is held or a RAW/WAW hazard is pending.
module operand_fetch_stage
   import cpu_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs0,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic              in_rd_en,
   output logic [ADDR_W-1:0] rf_ra0,
   output logic [ADDR_W-1:0] rf_ra1,
   input  logic [DATA_W-1:0] rf_out0,
   input  logic [DATA_W-1:0] rf_out1,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_op0,
   output logic [DATA_W-1:0] out_op1,
   output logic [ADDR_W-1:0] out_rd,
   output logic              out_rd_en,
   output logic [NREG-1:0]   sb_busy
);

   logic  clr0, clr1, clr_d;
   logic  haz;
   logic  accept;
   word_t fwd0, fwd1;

   assign rf_ra0 = in_rs0;
   assign rf_ra1 = in_rs1;

   // A write-back landing this cycle both supplies the data and retires the pending bit.
   assign clr0 = wb_we && (wb_wa == in_rs0);
   assign clr1 = wb_we && (wb_wa == in_rs1);
   assign clr_d = wb_we && (wb_wa == in_rd);

   assign fwd0 = clr0 ? wb_wd : rf_out0;
   assign fwd1 = clr1 ? wb_wd : rf_out1;

   assign haz = (sb_busy[in_rs0] && !clr0)
             || (sb_busy[in_rs1] && !clr1)
             || (in_rd_en && sb_busy[in_rd] && !clr_d);

   assign in_ready = (!out_valid || out_ready) && !haz;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_op0   <= '0;
         out_op1   <= '0;
         out_rd    <= '0;
         out_rd_en <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_op0   <= fwd0;
         out_op1   <= fwd1;
         out_rd    <= in_rd;
         out_rd_en <= in_rd_en;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   scoreboard u_scoreboard (
      .clock   (clock),
      .reset   (reset),
      .set_en  (accept && in_rd_en),
      .set_idx (in_rd),
      .clr_en  (wb_we),
      .clr_idx (wb_wa),
      .busy    (sb_busy)
   );

endmodule
